// File: rtl/sd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sd_pkg
// Purpose  : Shared definitions for the SD host serial line blocks (state
//            encoding, CRC7 polynomial and length, idle line level).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package sd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CRC   = 2'd2,
    DONE  = 2'd3
  } sd_state_t;

  // x^7 + x^3 + 1 with the x^7 term implied
  localparam logic [6:0] CRC7_POLY    = 7'h09;
  localparam int         CRC7_LEN     = 7;
  localparam logic       SD_LINE_IDLE = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sd_crc7.sv
`default_nettype none
// ============================================================================
// Module   : sd_crc7
// Purpose  : Bit-serial CRC7 (x^7+x^3+1, zero seed), shared by the SD
//            transmit and receive paths.
// Ports    : clk     - rising-edge clock
//            reset   - synchronous active-low reset
//            clear   - synchronous clear to the zero seed
//            enable  - advance the CRC by one bit
//            data_in - serial data bit
//            crc     - current CRC remainder, crc[6] is the MSB
// Revision : 1.0 - initial release
// ============================================================================
module sd_crc7
  import sd_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                enable,
  input  logic                data_in,
  output logic [CRC7_LEN-1:0] crc
);

  logic [CRC7_LEN-1:0] r_crc;
  logic                w_fb;

  assign w_fb = data_in ^ r_crc[CRC7_LEN-1];

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      r_crc <= '0;
    end else if (enable) begin
      r_crc <= {r_crc[CRC7_LEN-2:0], 1'b0} ^ (w_fb ? CRC7_POLY : 7'h00);
    end
  end

  assign crc = r_crc;

endmodule
`default_nettype wire

// File: rtl/serializer.sv
`default_nettype none
// ============================================================================
// Module   : serializer
// Purpose  : Parallel-to-serial transmitter for the SD CMD/DAT lines. A word
//            is captured on load and shifted out LSB first, one bit per
//            enabled clock; complete flags the end of the frame.
//            Optional feature macro: SERIALIZER_CRC7_EN appends a 7-bit CRC7
//            (MSB first) after the payload.
// Ports    : clk       - serial bit clock
//            reset     - synchronous active-low reset
//            enable    - shift qualifier, state frozen when low
//            load      - start strobe, accepted in IDLE or DONE only
//            framesize - payload bit count (clamped to BITS)
//            in        - parallel word to transmit
//            out       - registered serial data, idles high
//            busy      - frame in progress
//            complete  - frame sent, held until next load or reset
// Revision : 1.0 - initial release
// ============================================================================
module serializer
  import sd_pkg::*;
#(
  parameter int BITS         = 32,
  parameter int BITS_COUNTER = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    load,
  input  logic [BITS_COUNTER-1:0] framesize,
  input  logic [BITS-1:0]         in,
  output logic                    out,
  output logic                    busy,
  output logic                    complete
);

  localparam logic [BITS_COUNTER-1:0] c_BITS = BITS_COUNTER'(BITS);
  localparam logic [BITS_COUNTER-1:0] c_ONE  = BITS_COUNTER'(1);

  sd_state_t               r_state, w_state_next;
  logic [BITS-1:0]         r_shift, w_shift_next;
  logic [BITS_COUNTER-1:0] r_fs, w_fs_next;
  logic [BITS_COUNTER-1:0] r_counter, w_counter_next;
  logic                    r_out, w_out_next;
  logic                    r_complete, w_complete_next;
  logic [BITS_COUNTER-1:0] w_fs_eff;

`ifdef SERIALIZER_CRC7_EN
  localparam logic [BITS_COUNTER-1:0] c_CRC_LAST = BITS_COUNTER'(CRC7_LEN - 1);
  logic [CRC7_LEN-1:0] w_crc;
  logic                w_crc_clr;
  logic                w_crc_en;
  logic                w_crc_din;
`endif

  assign w_fs_eff = (framesize > c_BITS) ? c_BITS : framesize;

  always_comb begin
    w_state_next    = r_state;
    w_shift_next    = r_shift;
    w_fs_next       = r_fs;
    w_counter_next  = r_counter;
    w_out_next      = r_out;
    w_complete_next = r_complete;
    case (r_state)
      IDLE, DONE: begin
        // load does not need enable; it also clears a pending complete
        if (load) begin
          w_shift_next   = in;
          w_fs_next      = w_fs_eff;
          w_counter_next = '0;
          w_out_next     = SD_LINE_IDLE;
          if (w_fs_eff == '0) begin
            w_state_next    = DONE;
            w_complete_next = 1'b1;
          end else begin
            w_state_next    = SHIFT;
            w_complete_next = 1'b0;
          end
        end else if (enable) begin
          w_out_next = SD_LINE_IDLE;
        end
      end
      SHIFT: begin
        if (enable) begin
          w_out_next     = r_shift[0];
          w_shift_next   = r_shift >> 1;
          w_counter_next = r_counter + c_ONE;
          if (r_counter == r_fs - c_ONE) begin
`ifdef SERIALIZER_CRC7_EN
            w_state_next = CRC;
`else
            w_state_next    = DONE;
            w_complete_next = 1'b1;
`endif
          end
        end
      end
`ifdef SERIALIZER_CRC7_EN
      CRC: begin
        // counter keeps running from fs, so the last CRC bit is at fs+6
        if (enable) begin
          w_out_next     = w_crc[CRC7_LEN-1];
          w_counter_next = r_counter + c_ONE;
          if (r_counter == r_fs + c_CRC_LAST) begin
            w_state_next    = DONE;
            w_complete_next = 1'b1;
          end
        end
      end
`endif
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_fs       <= '0;
      r_counter  <= '0;
      r_out      <= SD_LINE_IDLE;
      r_complete <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_shift    <= w_shift_next;
      r_fs       <= w_fs_next;
      r_counter  <= w_counter_next;
      r_out      <= w_out_next;
      r_complete <= w_complete_next;
    end
  end

`ifdef SERIALIZER_CRC7_EN
  // While in CRC, feeding crc[6] back in zeroes the feedback term, so the
  // register just shifts left and presents the remainder MSB first.
  assign w_crc_clr = load && ((r_state == IDLE) || (r_state == DONE));
  assign w_crc_en  = enable && ((r_state == SHIFT) || (r_state == CRC));
  assign w_crc_din = (r_state == CRC) ? w_crc[CRC7_LEN-1] : r_shift[0];

  sd_crc7 u_crc7 (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_crc_clr),
    .enable  (w_crc_en),
    .data_in (w_crc_din),
    .crc     (w_crc)
  );
`endif

  assign out      = r_out;
  assign complete = r_complete;
  assign busy     = (r_state == SHIFT) || (r_state == CRC);

endmodule
`default_nettype wire
